timer_host_sequencer: RTL and testbench

//  Avalon-MM initiator that drives the 16-bit interval-timer slave (6 regs, no waitrequest, 1-cycle registered readdata).

---
 rtl/timer_host_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_timer_host_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_host_sequencer.sv
// ---------------------------------------------------------------------------
// timer_host_sequencer
// Avalon-MM initiator for a 16-bit interval-timer slave (6 registers, no
// waitrequest, readdata registered one cycle after the read address).
// Turns start/stop/snapshot commands into timer register accesses and
// services the timer interrupt on its own: the status register is cleared
// and a one-cycle tick is emitted per serviced interrupt.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake (accept on valid & ready)
//   cmd_op              00 start, 01 stop, 10 snapshot, 11 reserved
//   cmd_period          32-bit period used by start
//   cmd_continuous      CONT bit used by start
//   cmd_err             1-cycle pulse: reserved op or start with period 0
//   address, chipselect, write_n, writedata, readdata   Avalon-MM to timer
//   irq                 timer interrupt (level)
//   tick, tick_count    serviced-interrupt pulse and counter (wraps)
//   snap_valid, snap_value   snapshot strobe and captured 32-bit counter
// ---------------------------------------------------------------------------
module timer_host_sequencer #(
    parameter int TICK_W       = 16,
    parameter bit SNAP_ON_TICK = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [31:0]       cmd_period,
    input  logic              cmd_continuous,
    output logic              cmd_err,
    output logic [2:0]        address,
    output logic              chipselect,
    output logic              write_n,
    output logic [15:0]       writedata,
    input  logic [15:0]       readdata,
    input  logic              irq,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              snap_valid,
    output logic [31:0]       snap_value
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_WR_PL   = 4'd1;
    localparam logic [3:0] S_WR_PH   = 4'd2;
    localparam logic [3:0] S_WR_CTRL = 4'd3;
    localparam logic [3:0] S_WR_STAT = 4'd4;
    localparam logic [3:0] S_WR_SNAP = 4'd5;
    localparam logic [3:0] S_RD_L    = 4'd6;
    localparam logic [3:0] S_RD_H    = 4'd7;
    localparam logic [3:0] S_RD_CAP  = 4'd8;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_SNAP  = 2'b10;

    logic [3:0]  r_state;
    logic [31:0] r_period;
    logic        r_cont;
    logic [15:0] r_snap_lo;

    logic [3:0]  w_next;
    logic        w_idle;
    logic        w_accept;
    logic        w_cmd_bad;
    logic        w_start_ok;
    logic [2:0]  w_addr;
    logic        w_cs;
    logic        w_wn;
    logic [15:0] w_wd;

    // A pending irq blocks the command port so service always wins.
    assign w_idle     = (r_state == S_IDLE);
    assign cmd_ready  = w_idle & ~irq & ~reset;
    assign w_accept   = w_idle & ~irq & cmd_valid;
    assign w_start_ok = (cmd_op == OP_START) && (cmd_period != 32'd0);
    assign w_cmd_bad  = (cmd_op == 2'b11) ||
                        ((cmd_op == OP_START) && (cmd_period == 32'd0));

    // Next-state selection for the access sequencer.
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (irq) begin
                    w_next = S_WR_STAT;
                end else if (cmd_valid) begin
                    case (cmd_op)
                        OP_START: w_next = (cmd_period != 32'd0) ? S_WR_PL : S_IDLE;
                        OP_STOP:  w_next = S_WR_CTRL;
                        OP_SNAP:  w_next = S_WR_SNAP;
                        default:  w_next = S_IDLE;
                    endcase
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WR_PL:   w_next = S_WR_PH;
            S_WR_PH:   w_next = S_WR_CTRL;
            S_WR_CTRL: w_next = S_IDLE;
            S_WR_STAT: w_next = SNAP_ON_TICK ? S_WR_SNAP : S_IDLE;
            S_WR_SNAP: w_next = S_RD_L;
            S_RD_L:    w_next = S_RD_H;
            S_RD_H:    w_next = S_RD_CAP;
            S_RD_CAP:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Bus access for the state being entered, so the registered bus lines
    // up with r_state. WR_PL is only entered from IDLE, hence the live
    // cmd_period; WR_CTRL entered from IDLE is always a stop.
    always_comb begin
        w_addr = 3'd0;
        w_cs   = 1'b0;
        w_wn   = 1'b1;
        w_wd   = 16'h0000;
        case (w_next)
            S_WR_PL: begin
                w_addr = 3'd2; w_cs = 1'b1; w_wn = 1'b0; w_wd = cmd_period[15:0];
            end
            S_WR_PH: begin
                w_addr = 3'd3; w_cs = 1'b1; w_wn = 1'b0; w_wd = r_period[31:16];
            end
            S_WR_CTRL: begin
                w_addr = 3'd1; w_cs = 1'b1; w_wn = 1'b0;
                if (w_idle) begin
                    w_wd = 16'h0008;
                end else begin
                    w_wd = {13'd0, 1'b1, r_cont, 1'b1};
                end
            end
            S_WR_STAT: begin
                w_addr = 3'd0; w_cs = 1'b1; w_wn = 1'b0; w_wd = 16'h0000;
            end
            S_WR_SNAP: begin
                w_addr = 3'd4; w_cs = 1'b1; w_wn = 1'b0; w_wd = 16'h0000;
            end
            S_RD_L: begin
                w_addr = 3'd4; w_cs = 1'b1; w_wn = 1'b1; w_wd = 16'h0000;
            end
            S_RD_H: begin
                w_addr = 3'd5; w_cs = 1'b1; w_wn = 1'b1; w_wd = 16'h0000;
            end
            default: begin
                w_addr = 3'd0; w_cs = 1'b0; w_wn = 1'b1; w_wd = 16'h0000;
            end
        endcase
    end

    // State, registered bus, command latch, tick and snapshot capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_period   <= 32'd0;
            r_cont     <= 1'b0;
            r_snap_lo  <= 16'h0000;
            address    <= 3'd0;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            writedata  <= 16'h0000;
            cmd_err    <= 1'b0;
            tick       <= 1'b0;
            tick_count <= '0;
            snap_valid <= 1'b0;
            snap_value <= 32'd0;
        end else begin
            r_state    <= w_next;
            address    <= w_addr;
            chipselect <= w_cs;
            write_n    <= w_wn;
            writedata  <= w_wd;
            cmd_err    <= w_accept & w_cmd_bad;
            tick       <= (r_state == S_WR_STAT);
            snap_valid <= (r_state == S_RD_CAP);
            if (w_accept) begin
                r_period <= cmd_period;
                r_cont   <= cmd_continuous;
            end
            if (w_accept && w_start_ok) begin
                tick_count <= '0;
            end else if (r_state == S_WR_STAT) begin
                tick_count <= tick_count + 1'b1;
            end
            // readdata trails the read address by one cycle: the low half
            // is on the bus during RD_H, the high half during RD_CAP.
            if (r_state == S_RD_H) begin
                r_snap_lo <= readdata;
            end
            if (r_state == S_RD_CAP) begin
                snap_value <= {readdata, r_snap_lo};
            end
        end
    end

endmodule

// File: tb/tb_timer_host_sequencer.sv
`timescale 1ns/1ps
module tb_timer_host_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_continuous, cmd_err;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_period;
    logic [2:0]  address;
    logic        chipselect, write_n;
    logic [15:0] writedata, readdata;
    logic        irq, tick, snap_valid;
    logic [15:0] tick_count;
    logic [31:0] snap_value;

    // second instance: TICK_W=4 with a directly driven irq
    logic        cmd_ready2, cmd_err2, cs2, wn2, tick2, snap_valid2, irq2, irq2_set;
    logic [2:0]  addr2;
    logic [15:0] wd2;
    logic [3:0]  tick_count2;
    logic [31:0] snap_value2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    timer_host_sequencer #(.TICK_W(16), .SNAP_ON_TICK(1'b0)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
        .cmd_err(cmd_err), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
        .tick(tick), .tick_count(tick_count), .snap_valid(snap_valid),
        .snap_value(snap_value)
    );

    timer_host_sequencer #(.TICK_W(4), .SNAP_ON_TICK(1'b0)) dut2 (
        .clk(clk), .reset(reset), .cmd_valid(1'b0), .cmd_ready(cmd_ready2),
        .cmd_op(2'b00), .cmd_period(32'd0), .cmd_continuous(1'b0),
        .cmd_err(cmd_err2), .address(addr2), .chipselect(cs2),
        .write_n(wn2), .writedata(wd2), .readdata(16'h0000), .irq(irq2),
        .tick(tick2), .tick_count(tick_count2), .snap_valid(snap_valid2),
        .snap_value(snap_value2)
    );

    // ---------------- interval timer slave model ----------------
    logic [15:0] m_pl, m_ph, m_snl, m_snh;
    logic [31:0] m_cnt;
    logic        m_to, m_run, m_cont, m_ito;
    logic        m_hold;   // freezes the countdown (driven by stimulus)

    assign irq = m_to & m_ito;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pl <= 16'h0; m_ph <= 16'h0; m_snl <= 16'h0; m_snh <= 16'h0;
            m_cnt <= 32'd0; m_to <= 1'b0; m_run <= 1'b0; m_cont <= 1'b0;
            m_ito <= 1'b0; readdata <= 16'h0;
        end else begin
            if (m_run && !m_hold) begin
                if (m_cnt == 32'd0) begin
                    m_to <= 1'b1;
                    if (m_cont) m_cnt <= {m_ph, m_pl};
                    else        m_run <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 32'd1;
                end
            end
            readdata <= 16'h0;
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_to <= 1'b0;
                    3'd1: begin
                        m_ito  <= writedata[0];
                        m_cont <= writedata[1];
                        if (writedata[2]) begin m_run <= 1'b1; m_cnt <= {m_ph, m_pl}; end
                        if (writedata[3]) m_run <= 1'b0;
                    end
                    3'd2: m_pl <= writedata;
                    3'd3: m_ph <= writedata;
                    3'd4: begin m_snl <= m_cnt[15:0]; m_snh <= m_cnt[31:16]; end
                    default: ;
                endcase
            end else if (chipselect && write_n) begin
                if (address == 3'd4)      readdata <= m_snl;
                else if (address == 3'd5) readdata <= m_snh;
                else                      readdata <= 16'h0;
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset)                               irq2 <= 1'b0;
        else if (cs2 && !wn2 && addr2 == 3'd0)   irq2 <= 1'b0;
        else if (irq2_set)                       irq2 <= 1'b1;
    end

    // ---------------- monitors (sampled on the falling edge) ----------------
    logic [35:0] log_q[$];     // {cycle[15:0], write_n, address, writedata}
    logic        stat_prev = 1'b0;
    logic        gap_en = 1'b0;
    int          irq_bad = 0, gap_bad = 0, ticks = 0, errs = 0, snap_cyc = 0;
    int          last_tick = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chipselect) log_q.push_back({cyc[15:0], write_n, address, writedata});
        if (stat_prev && irq) irq_bad <= irq_bad + 1;
        stat_prev <= chipselect && !write_n && (address == 3'd0);
        if (cmd_err) errs <= errs + 1;
        if (snap_valid) snap_cyc <= cyc;
        if (!gap_en) begin
            last_tick <= -1;
        end else if (tick) begin
            if (last_tick >= 0 && ((cyc - last_tick) < 10 || (cyc - last_tick) > 11))
                gap_bad <= gap_bad + 1;
            last_tick <= cyc;
        end
        if (tick) ticks <= ticks + 1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Call at a falling edge; holds cmd_valid until accepted (bounded).
    task automatic send_cmd(input logic [1:0] op, input logic [31:0] per, input logic cont);
        bit done = 1'b0;
        cmd_op = op; cmd_period = per; cmd_continuous = cont; cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin
                @(posedge clk);
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) check("cmd_accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    int base, bad, e0;
    bit seen;

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_period = 32'd0;
        cmd_continuous = 1'b0; m_hold = 1'b1; irq2_set = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_write_n", write_n, 1'b1);
        check("rst_chipselect", chipselect, 1'b0);
        check("rst_tick_count", tick_count, 16'd0);
        check("rst_snap_value", snap_value, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1'b1);

        // 1: start with period 0x186A0, continuous
        log_q.delete();
        send_cmd(2'b00, 32'h0001_86A0, 1'b1);
        repeat (6) @(negedge clk);
        check("t1_nacc", log_q.size(), 3);
        check("t1_pl", log_q[0][19:0], {1'b0, 3'd2, 16'h86A0});
        check("t1_ph", log_q[1][19:0], {1'b0, 3'd3, 16'h0001});
        check("t1_ctrl", log_q[2][19:0], {1'b0, 3'd1, 16'h0007});
        check("t1_consec1", log_q[1][35:20] - log_q[0][35:20], 16'd1);
        check("t1_consec2", log_q[2][35:20] - log_q[1][35:20], 16'd1);
        check("t1_ready", cmd_ready, 1'b1);

        // 3: snapshot with the counter frozen at 0x0002_0003
        send_cmd(2'b00, 32'h0002_0003, 1'b0);
        repeat (6) @(negedge clk);
        check("t3_ctrl_oneshot", log_q[log_q.size()-1][19:0], {1'b0, 3'd1, 16'h0005});
        log_q.delete();
        send_cmd(2'b10, 32'd0, 1'b0);
        repeat (8) @(negedge clk);
        check("t3_nacc", log_q.size(), 3);
        check("t3_w4", log_q[0][19:0], {1'b0, 3'd4, 16'h0000});
        check("t3_r4", log_q[1][19:0], {1'b1, 3'd4, 16'h0000});
        check("t3_r5", log_q[2][19:0], {1'b1, 3'd5, 16'h0000});
        check("t3_snap_value", snap_value, 32'h0002_0003);
        check("t3_snap_latency", snap_cyc - log_q[2][35:20], 2);

        // 2: period 10, continuous, five serviced interrupts
        m_hold = 1'b0;
        send_cmd(2'b00, 32'd10, 1'b1);
        repeat (4) @(negedge clk);
        log_q.delete();
        gap_en = 1'b1;
        base = ticks;
        for (int i = 0; i < 300 && (ticks - base) < 5; i++) @(negedge clk);
        check("t2_ticks_seen", ticks - base, 5);
        check("t2_tick_count", tick_count, 16'd5);
        check("t2_gap", gap_bad, 0);
        check("t2_nstat", log_q.size(), 5);
        bad = 0;
        foreach (log_q[i]) if (log_q[i][19:0] != {1'b0, 3'd0, 16'h0000}) bad++;
        check("t2_stat_writes", bad, 0);
        check("t2_irq_after_stat", irq_bad, 0);

        // 4: irq and stop command in the same IDLE cycle
        gap_en = 1'b0;
        log_q.delete();
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (irq) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("t4_irq_seen", seen, 1'b1);
        check("t4_ready_blocked", cmd_ready, 1'b0);
        send_cmd(2'b01, 32'd0, 1'b0);
        repeat (6) @(negedge clk);
        check("t4_nacc", log_q.size(), 2);
        check("t4_stat_first", log_q[0][19:0], {1'b0, 3'd0, 16'h0000});
        check("t4_stop", log_q[1][19:0], {1'b0, 3'd1, 16'h0008});
        repeat (30) @(negedge clk);
        check("t4_irq_low", irq, 1'b0);
        check("t4_tick_count_held", tick_count, 16'd6);
        check("t4_no_more_acc", log_q.size(), 2);

        // 5: start with period 0 and reserved op
        e0 = errs;
        log_q.delete();
        send_cmd(2'b00, 32'd0, 1'b1);
        repeat (3) @(negedge clk);
        check("t5_err_p0", errs - e0, 1);
        send_cmd(2'b11, 32'h1234, 1'b0);
        repeat (3) @(negedge clk);
        check("t5_err_total", errs - e0, 2);
        check("t5_no_bus", log_q.size(), 0);

        // 5b: TICK_W=4 wraps after 16 services
        for (int k = 0; k < 17; k++) begin
            irq2_set = 1'b1;
            @(negedge clk);
            irq2_set = 1'b0;
            repeat (5) @(negedge clk);
            if (k == 15) check("t5_wrap0", tick_count2, 4'd0);
        end
        check("t5_wrap1", tick_count2, 4'd1);

        // 6: reset during WR_PH
        m_hold = 1'b1;
        cmd_op = 2'b00; cmd_period = 32'h1234_5678; cmd_continuous = 1'b0; cmd_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (chipselect && address == 3'd3) begin seen = 1'b1; break; end
        end
        check("t6_ph_seen", seen, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("t6_async_cs", chipselect, 1'b0);
        check("t6_async_wn", write_n, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t6_ready", cmd_ready, 1'b1);
        check("t6_idle_bus", chipselect, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
